ppc_fetch_queue: RTL and testbench

PPC_FETCH_QUEUE -- requirements
Module: ppc_fetch_queue

---
 rtl/ppc_fetch_queue.sv | 136 +++++++++++++
 tb/tb_ppc_fetch_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppc_fetch_queue.sv
// PowerPC-style instruction fetch unit: fetches doublewords into a small in-order queue.
// Optional stall counter output is enabled by defining FETCH_PERF_EN.
module ppc_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [0:63] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [0:60] readAddr,
    input  logic [0:63] readData,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [0:31] inst,
    output logic [0:63] inst_pc,
    input  logic        redirect_valid,
    input  logic [0:63] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [0:31] stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FETCH_LIMIT = CW'(DEPTH - 2);
    localparam logic [0:63]   RESET_FPC   = {RESET_PC[0:61], 2'b00};

    logic [0:63]   fpc_q, fpc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:31]   inst_mem_q [DEPTH];
    logic [0:31]   inst_mem_d [DEPTH];
    logic [0:63]   pc_mem_q [DEPTH];
    logic [0:63]   pc_mem_d [DEPTH];

    logic          fetch;
    logic          do_pop;
    logic [PW-1:0] tail_nxt;
    logic [CW-1:0] push_cnt;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[62:63];

    assign readAddr   = fpc_q[0:60];
    assign inst_valid = (count_q != '0) & ~redirect_valid;
    assign inst       = inst_mem_q[head_q];
    assign inst_pc    = pc_mem_q[head_q];

    // Fetching only with room for two pushes keeps the queue from ever overflowing.
    assign fetch    = (count_q <= FETCH_LIMIT) & ~redirect_valid;
    assign do_pop   = inst_valid & inst_ready;
    assign tail_nxt = tail_q + PW'(1);

    always_comb begin
        fpc_d      = fpc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        push_cnt   = '0;

        if (redirect_valid) begin
            fpc_d   = {redirect_pc[0:61], 2'b00};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (fetch) begin
                if (!fpc_q[61]) begin
                    inst_mem_d[tail_q]   = readData[0:31];
                    pc_mem_d[tail_q]     = fpc_q;
                    inst_mem_d[tail_nxt] = readData[32:63];
                    pc_mem_d[tail_nxt]   = fpc_q + 64'd4;
                    tail_d               = tail_nxt + PW'(1);
                    push_cnt             = CW'(2);
                    fpc_d                = fpc_q + 64'd8;
                end else begin
                    // Odd word: only the upper half of the doubleword is on the path.
                    inst_mem_d[tail_q] = readData[32:63];
                    pc_mem_d[tail_q]   = fpc_q;
                    tail_d             = tail_nxt;
                    push_cnt           = CW'(1);
                    fpc_d              = fpc_q + 64'd4;
                end
            end
            if (do_pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + push_cnt - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q   <= RESET_FPC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            fpc_q      <= fpc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [0:31] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!inst_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ppc_fetch_queue.sv
// Scoreboard bench for ppc_fetch_queue: the expected instruction stream is the sequential
// program path from the reset/redirect address, popped by a monitor on every handshake.
module tb_ppc_fetch_queue;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [60:0] read_addr;
    logic [63:0] read_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    logic [60:0] w_read_addr;
    logic [63:0] w_read_data;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [63:0] w_pc;
    logic [63:0] w_exp_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] w_stall_cnt;
    logic [31:0] s0;
`endif

    int   checks;
    int   failures;
    int   pops;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [63:0] model_next_pc;

    // Instruction memory contents; address 0 holds the known li/sc pair.
    function automatic logic [31:0] word_at(input logic [63:0] a);
        if (a == 64'h0) return 32'h3860_0041;
        if (a == 64'h4) return 32'h4400_0002;
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    assign read_data   = {word_at({read_addr, 3'b000}), word_at({read_addr, 3'b100})};
    assign w_read_data = {word_at({w_read_addr, 3'b000}), word_at({w_read_addr, 3'b100})};

    ppc_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .readAddr       (read_addr),
        .readData       (read_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    ppc_fetch_queue #(.DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .readAddr       (w_read_addr),
        .readData       (w_read_data),
        .inst_valid     (w_valid),
        .inst_ready     (1'b1),
        .inst           (w_inst),
        .inst_pc        (w_pc),
        .redirect_valid (1'b0),
        .redirect_pc    (64'h0)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt      (w_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic void extend_path();
        while (exp_q.size() < 32) begin
            exp_q.push_back('{pc: model_next_pc, word: word_at(model_next_pc)});
            model_next_pc = model_next_pc + 64'd4;
        end
    endfunction

    function automatic void start_path(input logic [63:0] pc);
        exp_q.delete();
        model_next_pc = {pc[63:2], 2'b00};
        extend_path();
    endfunction

    // Drives one cycle of inputs and returns 1 time unit after the edge that consumes them.
    task automatic applyStimulus(input logic rdy, input logic redir, input logic [63:0] tgt);
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (redir) start_path(tgt);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (redirect_valid) begin
                checkOutput("redirect_hides_valid", 64'(inst_valid), 64'h0);
            end else if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL scoreboard_empty: got pc %h expected no output", inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("head_pc", inst_pc, mon_e.pc);
                    checkOutput("head_inst", 64'(inst), 64'(mon_e.word));
                    pops++;
                    extend_path();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            w_exp_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        end else if (w_valid) begin
            checkOutput("wrap_pc", w_pc, w_exp_pc);
            checkOutput("wrap_inst", 64'(w_inst), 64'(word_at(w_exp_pc)));
            w_exp_pc = w_exp_pc + 64'd4;
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        pops           = 0;
        rst_n          = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        start_path(64'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 64'(inst_valid), 64'h0);
        checkOutput("reset_inst", 64'(inst), 64'h0);
        checkOutput("reset_pc", inst_pc, 64'h0);
        checkOutput("reset_addr", 64'(read_addr), 64'h0);

        rst_n = 1'b1;
        #1;
        checkOutput("no_output_before_fetch", 64'(inst_valid), 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h0);
        checkOutput("first_valid", 64'(inst_valid), 64'h1);
        checkOutput("first_inst", 64'(inst), 64'h3860_0041);
        checkOutput("first_pc", inst_pc, 64'h0);
`ifdef FETCH_PERF_EN
        checkOutput("stall_after_reset", 64'(stall_cnt), 64'h1);
`endif
        applyStimulus(1'b1, 1'b0, 64'h0);
        checkOutput("second_inst", 64'(inst), 64'h4400_0002);
        checkOutput("second_pc", inst_pc, 64'h4);

        // Consumer stalls: fetching must stop once the queue cannot take two more.
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 64'h0);
        checkOutput("stall_addr_frozen", 64'(read_addr), 64'h2);
        checkOutput("stall_valid", 64'(inst_valid), 64'h1);
        checkOutput("stall_head_pc", inst_pc, 64'h4);
`ifdef FETCH_PERF_EN
        checkOutput("stall_cnt_steady", 64'(stall_cnt), 64'h1);
`endif
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 64'h0);

        // Redirect onto an odd word while the queue is full.
`ifdef FETCH_PERF_EN
        s0 = stall_cnt;
`endif
        applyStimulus(1'b1, 1'b1, 64'h16);
        checkOutput("redir_addr", 64'(read_addr), 64'h2);
        redirect_valid = 1'b0;
        #1;
        checkOutput("redir_queue_empty", 64'(inst_valid), 64'h0);
        applyStimulus(1'b1, 1'b0, 64'h0);
        checkOutput("redir_first_valid", 64'(inst_valid), 64'h1);
        checkOutput("redir_first_pc", inst_pc, 64'h14);
        checkOutput("redir_first_inst", 64'(inst), 64'(word_at(64'h14)));
        checkOutput("redir_next_addr", 64'(read_addr), 64'h3);
        applyStimulus(1'b1, 1'b0, 64'h0);
        checkOutput("redir_second_pc", inst_pc, 64'h18);
`ifdef FETCH_PERF_EN
        checkOutput("stall_cnt_redirect", 64'(stall_cnt), 64'(s0 + 32'd2));
`endif

        for (int i = 0; i < 1500; i++) begin
            logic        rdy;
            logic        redir;
            logic [63:0] tgt;
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
            else tgt = {$urandom(), $urandom()};
            if (i == 700) begin
                rst_n = 1'b0;
                start_path(64'h0);
                #1;
                checkOutput("midreset_valid", 64'(inst_valid), 64'h0);
                checkOutput("midreset_inst", 64'(inst), 64'h0);
                checkOutput("midreset_pc", inst_pc, 64'h0);
                checkOutput("midreset_addr", 64'(read_addr), 64'h0);
                @(posedge clk);
                #1;
                rst_n          = 1'b1;
                redirect_valid = 1'b0;
                #1;
                checkOutput("midreset_no_output", 64'(inst_valid), 64'h0);
            end
            applyStimulus(rdy, redir, tgt);
        end

        checkOutput("handshake_progress", 64'(pops > 200), 64'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
